// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency generator and frequency measurement blocks.
package freq_pkg;
  localparam int CNT_W_DEFAULT = 16;
  localparam int MIN_PERIOD    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/freq_gen_cfg.sv
// Active/pending period and high-time registers for freq_gen: clamp, reject and deferred update.
module freq_gen_cfg
  import freq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idle,
  input  logic             bnd,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] per_s,
  output logic [CNT_W-1:0] hi_nxt,
  output logic             upd_pend,
  output logic             cfg_err
);

  logic [CNT_W-1:0] hi_s;
  logic [CNT_W-1:0] per_p;
  logic [CNT_W-1:0] hi_p;
  logic [CNT_W-1:0] hi_clamp;
  logic             load_ok;
  logic             direct;
  logic             commit;

  assign load_ok  = load && (period >= CNT_W'(MIN_PERIOD));
  assign hi_clamp = (high_time >= period) ? period - CNT_W'(1) : high_time;
  assign direct   = load_ok && idle;
  // A pending value left over when the generator stops is applied while idle.
  assign commit   = upd_pend && (idle || bnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_s    <= '0;
      hi_s     <= '0;
      per_p    <= '0;
      hi_p     <= '0;
      upd_pend <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (load && !load_ok) cfg_err <= 1'b1;
      if (direct) begin
        per_s    <= period;
        hi_s     <= hi_clamp;
        upd_pend <= 1'b0;
      end else begin
        if (commit) begin
          per_s <= per_p;
          hi_s  <= hi_p;
        end
        if (load_ok) begin
          per_p    <= period;
          hi_p     <= hi_clamp;
          upd_pend <= 1'b1;
        end else if (commit) begin
          upd_pend <= 1'b0;
        end
      end
    end
  end

  // High time that will be active in the next cycle, so freq_out can be registered.
  always_comb begin
    hi_nxt = hi_s;
    if (direct)      hi_nxt = hi_clamp;
    else if (commit) hi_nxt = hi_p;
  end

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator with period-boundary updates.
// Optional burst mode: define FREQ_GEN_BURST_EN to add burst_len/burst_done.
//
// state | meaning
// IDLE  | outputs and phase counter held at 0, loads go straight to active regs
// RUN   | cnt sweeps 0..per_s-1, freq_out high while cnt < hi_s
module freq_gen
  import freq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  input  logic             load,
`ifdef FREQ_GEN_BURST_EN
  input  logic [15:0]      burst_len,
  output logic             burst_done,
`endif
  output logic             freq_out,
  output logic             edge_pulse,
  output logic             upd_pend,
  output logic             cfg_err
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] per_s;
  logic [CNT_W-1:0] hi_nxt;
  logic             fo_d;
  logic             bnd;
  logic             burst_stop;
  logic             start_ok;

  assign bnd = (state == RUN) && (cnt >= per_s - CNT_W'(1));

  freq_gen_cfg #(.CNT_W(CNT_W)) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state == IDLE),
    .bnd       (bnd),
    .load      (load),
    .period    (period),
    .high_time (high_time),
    .per_s     (per_s),
    .hi_nxt    (hi_nxt),
    .upd_pend  (upd_pend),
    .cfg_err   (cfg_err)
  );

`ifdef FREQ_GEN_BURST_EN
  logic [15:0] edge_cnt;
  logic        hold;

  // Edges never land on a boundary cycle (cnt=0 vs cnt=per_s-1, per_s>=2).
  assign burst_stop = bnd && (burst_len != 16'd0) && (edge_cnt >= burst_len);
  assign start_ok   = !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt   <= '0;
      hold       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_stop;
      if (state == IDLE)   edge_cnt <= '0;
      else if (edge_pulse) edge_cnt <= edge_cnt + 16'd1;
      if (burst_stop)   hold <= 1'b1;
      else if (!enable) hold <= 1'b0;
    end
  end
`else
  assign burst_stop = 1'b0;
  assign start_ok   = 1'b1;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      IDLE: if (enable && start_ok && (per_s >= CNT_W'(MIN_PERIOD))) state_d = RUN;
      RUN: begin
        if (!enable || burst_stop) state_d = IDLE;
        else if (!bnd)             cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    fo_d = (state_d == RUN) && (cnt_d < hi_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      freq_out   <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      freq_out   <= fo_d;
      edge_pulse <= fo_d & ~freq_out;
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// Directed self-checking bench for freq_gen (default build, burst mode off).
module tb_freq_gen;
  import freq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        load;
  logic        freq_out;
  logic        edge_pulse;
  logic        upd_pend;
  logic        cfg_err;
`ifdef FREQ_GEN_BURST_EN
  logic [15:0] burst_len;
  logic        burst_done;
`endif

  int n_chk;
  int n_err;

  freq_gen #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .load       (load),
`ifdef FREQ_GEN_BURST_EN
    .burst_len  (burst_len),
    .burst_done (burst_done),
`endif
    .freq_out   (freq_out),
    .edge_pulse (edge_pulse),
    .upd_pend   (upd_pend),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    period = '0;
    high_time = '0;
`ifdef FREQ_GEN_BURST_EN
    burst_len = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fo", freq_out, 0);
    chk("rst_ep", edge_pulse, 0);
    chk("rst_up", upd_pend, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;

    // enable without any valid load must not start
    enable = 1'b1;
    repeat (3) tick();
    chk("idle_no_cfg", freq_out, 0);
    enable = 1'b0;

    // basic 10/4, then live update to 6/3 loaded mid-period
    period = 16'd10; high_time = 16'd4; load = 1'b1;
    tick();
    load = 1'b0;
    chk("idle_load_no_pend", upd_pend, 0);
    enable = 1'b1;
    for (int i = 0; i < 38; i++) begin
      tick();
      chk("basic_fo", freq_out, (i < 20) ? ((i % 10) < 4) : (((i - 20) % 6) < 3));
      chk("basic_ep", edge_pulse, (i < 20) ? ((i % 10) == 0) : (((i - 20) % 6) == 0));
      chk("live_up", upd_pend, (i >= 13 && i <= 19));
      if (i == 12) begin
        load = 1'b1; period = 16'd6; high_time = 16'd3;
      end else begin
        load = 1'b0;
      end
    end

    // clamp 8/12 -> 7 high 1 low, with rejected loads period=1 and period=0
    enable = 1'b0;
    tick();
    chk("stop_fo", freq_out, 0);
    period = 16'd8; high_time = 16'd12; load = 1'b1;
    tick();
    load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("clamp_fo", freq_out, (i % 8) < 7);
      chk("clamp_ep", edge_pulse, (i % 8) == 0);
      chk("rej_err", cfg_err, i >= 4);
      chk("rej_up", upd_pend, 0);
      if (i == 3) begin
        load = 1'b1; period = 16'd1; high_time = 16'd0;
      end else if (i == 9) begin
        load = 1'b1; period = 16'd0; high_time = 16'd1;
      end else begin
        load = 1'b0;
      end
    end

    // high_time = 0 -> constant low
    load = 1'b0;
    enable = 1'b0;
    tick();
    period = 16'd5; high_time = 16'd0; load = 1'b1;
    tick();
    load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("zero_fo", freq_out, 0);
      chk("zero_ep", edge_pulse, 0);
    end

    // async reset in the middle of a high phase with an update pending
    enable = 1'b0;
    tick();
    period = 16'd10; high_time = 16'd4; load = 1'b1;
    tick();
    load = 1'b0;
    enable = 1'b1;
    tick();
    chk("restart_fo", freq_out, 1);
    chk("restart_ep", edge_pulse, 1);
    period = 16'd6; high_time = 16'd2; load = 1'b1;
    tick();
    load = 1'b0;
    chk("pre_rst_fo", freq_out, 1);
    chk("pre_rst_up", upd_pend, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fo", freq_out, 0);
    chk("async_rst_ep", edge_pulse, 0);
    chk("async_rst_up", upd_pend, 0);
    chk("async_rst_err", cfg_err, 0);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", freq_out, 0);
    period = 16'd4; high_time = 16'd1; load = 1'b1;
    tick();
    load = 1'b0;
    chk("post_rst_load_fo", freq_out, 0);
    tick();
    chk("post_rst_run_fo", freq_out, 1);
    chk("post_rst_run_ep", edge_pulse, 1);
    tick();
    chk("post_rst_low_fo", freq_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
